script_tokenizer: RTL
=====================

// Module: script_tokenizer
// PURPOSE
//  Upstream stage of the script evaluator. Accepts the raw serialized script byte
//  stream over a valid/ready handshake and decodes push opcodes:
//  OP_0, direct push 0x01-0x4b, OP_PUSHDATA1 0x4c and OP_PUSHDATA2 0x4d.
//  Emits one token per script element, either a data item (assembled into a
//  STACK_WIDTH word) or a plain opcode. The evaluator consumes these tokens.
// PARAMETERS
//  STACK_WIDTH     512               width of one data-stack item, in bits
//  MAX_PUSH_BYTES  STACK_WIDTH/8     largest push accepted, in bytes
//  LEN_W           $clog2(MAX_PUSH_BYTES+1)  width of tok_len
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            reset, asynchronous, active-low
//  restart      in   1            synchronous clear to IDLE; drops partial token, clears err
//  in_data      in   8            script byte
//  in_valid     in   1            in_data is valid
//  in_ready     out  1            byte accepted when in_valid && in_ready
//  in_last      in   1            qualifies the final script byte
//  tok_valid    out  1            token available
//  tok_ready    in   1            consumer takes token when tok_valid && tok_ready
//  tok_is_data  out  1            1 = data item, 0 = opcode
//  tok_opcode   out  8            opcode byte (the push opcode itself for data tokens)
//  tok_data     out  STACK_WIDTH  pushed bytes, right-aligned, zero-extended
//  tok_len      out  LEN_W        number of pushed bytes (0 for OP_0 and opcodes)
//  tok_last     out  1            token completes the script
//  err          out  1            sticky error flag
//  err_code     out  2            0 none, 1 length>MAX, 2 truncated, 3 PUSHDATA4 unsupported
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; data/length registers 0.
//  FSM states: IDLE, LEN1, LEN2_LO, LEN2_HI, DATA, EMIT, ERROR.
//  in_ready=1 in IDLE/LEN*/DATA; in_ready=0 in EMIT and ERROR.
//  IDLE, accepted byte b:
//   - b=0x00: data token, len 0, data 0 -> EMIT.
//   - 0x01..0x4b: remaining=b, data cleared -> DATA. b>MAX -> ERROR(1).
//   - 0x4c -> LEN1. 0x4d -> LEN2_LO. 0x4e -> ERROR(3).
//   - otherwise: opcode token -> EMIT.
//  LEN1: remaining=byte. Byte 0 -> empty data token -> EMIT. Byte>MAX -> ERROR(1). Else -> DATA.
//  LEN2_LO then LEN2_HI: length is little-endian {hi,lo}; same 0/>MAX/else rules on completion.
//  DATA: data<=(data<<8)|byte; remaining--; tok_len++.
//   - First stream byte ends up most significant of the len bytes.
//   - On the final byte (remaining==1) -> EMIT.
//  EMIT: tok_valid=1; token fields stable until tok_ready. On handshake -> IDLE, tok_valid=0.
//  Latency: tok_valid rises the cycle after the completing byte is accepted.
//   Throughput is one opcode per 2 cycles.
//  in_last on a token-completing byte -> tok_last=1 on that token.
//  in_last on any non-completing byte (LEN*, or DATA with remaining>1, or IDLE byte
//   starting a push) -> ERROR(2), no token emitted.
//  ERROR: err=1 and err_code held; in_ready=0; tok_valid=0 until restart or reset.
//  restart has priority over all events in the same cycle, including an in or tok handshake.
//   The next cycle is IDLE with err=0 and tok_valid=0.
//  Width rule: length compares are done at 16 bits before truncation to LEN_W.
// TESTING
//  1. Bytes 03 AA BB CC(last) -> one data token: len 3, data 0xAABBCC, last=1, opcode 0x03.
//  2. Bytes 76 A9 with tok_ready held low for 5 cycles -> token 0x76 held stable,
//     in_ready=0 throughout; then 0x76 followed by 0xA9.
//  3. Bytes 4C 02 11 22 then 4D 01 00 33 -> data 0x1122 (len 2), then data 0x33 (len 1).
//  4. Bytes 4D 41 00 with MAX=64 -> err=1, err_code=1, in_ready=0. Restart -> IDLE, err=0.
//  5. Bytes 05 01 02(last) -> err_code=2, no token. Byte 4E -> err_code=3.
//  6. Bytes 00 4C 00(last) -> two empty data tokens, the second with last=1.
//     Async reset asserted mid-DATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/script_tokenizer.sv
// rtl/script_tokenizer.sv - push-opcode tokenizer turning a script byte stream into data/opcode tokens
module script_tokenizer #(
    parameter int STACK_WIDTH    = 512,
    parameter int MAX_PUSH_BYTES = STACK_WIDTH / 8,
    parameter int LEN_W          = $clog2(MAX_PUSH_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    output logic                   tok_valid,
    input  logic                   tok_ready,
    output logic                   tok_is_data,
    output logic [7:0]             tok_opcode,
    output logic [STACK_WIDTH-1:0] tok_data,
    output logic [LEN_W-1:0]       tok_len,
    output logic                   tok_last,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN1    = 3'd1;
    localparam logic [2:0] S_LEN2_LO = 3'd2;
    localparam logic [2:0] S_LEN2_HI = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_EMIT    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PUSH_BYTES);

    logic [2:0]  state;
    logic [15:0] remaining;
    logic [7:0]  len_lo;
    logic        accept;
    logic [15:0] len_new;
    logic        len_zero;
    logic        too_big;

    // Gated by rst so every output reads 0 while reset is held.
    assign in_ready  = rst && (state == S_IDLE || state == S_LEN1 || state == S_LEN2_LO ||
                               state == S_LEN2_HI || state == S_DATA);
    assign tok_valid = rst && (state == S_EMIT);
    assign accept    = in_valid && in_ready;

    // Length candidate from the current byte; compared at full 16 bits.
    always_comb begin
        len_new  = (state == S_LEN2_HI) ? {in_data, len_lo} : {8'h00, in_data};
        len_zero = (len_new == 16'd0);
        too_big  = (len_new > MAX_LEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            len_lo      <= '0;
            tok_is_data <= 1'b0;
            tok_opcode  <= '0;
            tok_data    <= '0;
            tok_len     <= '0;
            tok_last    <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else if (restart) begin
            state       <= S_IDLE;
            remaining   <= '0;
            len_lo      <= '0;
            tok_is_data <= 1'b0;
            tok_opcode  <= '0;
            tok_data    <= '0;
            tok_len     <= '0;
            tok_last    <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    tok_opcode <= in_data;
                    tok_data   <= '0;
                    tok_len    <= '0;
                    tok_last   <= in_last;
                    if (in_data == 8'h00) begin
                        tok_is_data <= 1'b1;
                        state       <= S_EMIT;
                    end else if (in_data <= 8'h4b) begin
                        tok_is_data <= 1'b1;
                        if (too_big) begin
                            err <= 1'b1; err_code <= 2'd1; state <= S_ERROR;
                        end else if (in_last) begin
                            err <= 1'b1; err_code <= 2'd2; state <= S_ERROR;
                        end else begin
                            remaining <= len_new;
                            state     <= S_DATA;
                        end
                    end else if (in_data == 8'h4c || in_data == 8'h4d) begin
                        tok_is_data <= 1'b1;
                        if (in_last) begin
                            err <= 1'b1; err_code <= 2'd2; state <= S_ERROR;
                        end else begin
                            state <= (in_data == 8'h4c) ? S_LEN1 : S_LEN2_LO;
                        end
                    end else if (in_data == 8'h4e) begin
                        err <= 1'b1; err_code <= 2'd3; state <= S_ERROR;
                    end else begin
                        tok_is_data <= 1'b0;
                        state       <= S_EMIT;
                    end
                end
                S_LEN2_LO: if (accept) begin
                    if (in_last) begin
                        err <= 1'b1; err_code <= 2'd2; state <= S_ERROR;
                    end else begin
                        len_lo <= in_data;
                        state  <= S_LEN2_HI;
                    end
                end
                S_LEN1, S_LEN2_HI: if (accept) begin
                    if (len_zero) begin
                        tok_last <= in_last;
                        state    <= S_EMIT;
                    end else if (too_big) begin
                        err <= 1'b1; err_code <= 2'd1; state <= S_ERROR;
                    end else if (in_last) begin
                        err <= 1'b1; err_code <= 2'd2; state <= S_ERROR;
                    end else begin
                        remaining <= len_new;
                        state     <= S_DATA;
                    end
                end
                S_DATA: if (accept) begin
                    tok_data  <= {tok_data[STACK_WIDTH-9:0], in_data};
                    tok_len   <= tok_len + LEN_W'(1);
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        tok_last <= in_last;
                        state    <= S_EMIT;
                    end else if (in_last) begin
                        err <= 1'b1; err_code <= 2'd2; state <= S_ERROR;
                    end
                end
                S_EMIT: if (tok_ready) begin
                    state <= S_IDLE;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
